// File: rtl/freq_filter_stream.sv
// rtl/freq_filter_stream.sv - per-bin signed gain filter on a complex bin stream, double-buffered gains
module freq_filter_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 16,
   parameter int N          = 16,
   localparam int AW        = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_real,
   input  logic [DATA_WIDTH-1:0] in_imag,
   input  logic                  cfg_we,
   input  logic [AW-1:0]         cfg_addr,
   input  logic [GAIN_WIDTH-1:0] cfg_gain,
   input  logic                  cfg_commit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_real,
   output logic [DATA_WIDTH-1:0] out_imag,
   output logic [AW-1:0]         out_bin,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  commit_busy
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH;
   localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'((64'd1 << (GAIN_WIDTH - 1)) - 64'd1);
   localparam logic signed [PW-1:0]  RND      = PW'(64'd1 << (GAIN_WIDTH - 2));
   localparam logic signed [PW-1:0]  SAT_MAX  = PW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
   localparam logic signed [PW-1:0]  SAT_MIN  = ~SAT_MAX;
   localparam logic [AW-1:0]         LAST_BIN = AW'(N - 1);
   localparam logic [1:0]            MODE_BYPASS = 2'b00;
   localparam logic [1:0]            MODE_MASK   = 2'b01;
   localparam logic [1:0]            MODE_GAIN   = 2'b10;

   // Q1.(GW-1) multiply, round half up, saturate to the sample range
   function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [GAIN_WIDTH-1:0] g);
      logic signed [PW-1:0] xe;
      logic signed [PW-1:0] ge;
      logic signed [PW-1:0] r;
      xe = PW'($signed(x));
      ge = PW'($signed(g));
      r  = (xe * ge + RND) >>> (GAIN_WIDTH - 1);
      if (r > SAT_MAX)      scale = SAT_MAX[DATA_WIDTH-1:0];
      else if (r < SAT_MIN) scale = SAT_MIN[DATA_WIDTH-1:0];
      else                  scale = r[DATA_WIDTH-1:0];
   endfunction

   logic [GAIN_WIDTH-1:0] shadow_q [N];
   logic [GAIN_WIDTH-1:0] shadow_d [N];
   logic [GAIN_WIDTH-1:0] active_q [N];
   logic [GAIN_WIDTH-1:0] active_d [N];
   logic                  pending_q, pending_d;
   logic [AW-1:0]         bin_q, bin_d;
   logic [1:0]            frame_mode_q, frame_mode_d;

   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_real_q, s1_real_d;
   logic [DATA_WIDTH-1:0] s1_imag_q, s1_imag_d;
   logic [AW-1:0]         s1_bin_q, s1_bin_d;
   logic [GAIN_WIDTH-1:0] s1_gain_q, s1_gain_d;
   logic [1:0]            s1_mode_q, s1_mode_d;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_real_q, out_real_d;
   logic [DATA_WIDTH-1:0] out_imag_q, out_imag_d;
   logic [AW-1:0]         out_bin_q, out_bin_d;
   logic                  out_last_q, out_last_d;
   logic                  frame_done_q, frame_done_d;

   logic                  accept;
   logic                  copy_en;
   logic [DATA_WIDTH-1:0] res_real, res_imag;

   assign in_ready = !(out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;
   // Swap only on a frame boundary: idle at bin 0, or as the last bin is taken
   assign copy_en  = pending_q && ((bin_q == '0 && !accept) || (accept && bin_q == LAST_BIN));

   always_comb begin
      res_real = s1_real_q;
      res_imag = s1_imag_q;
      case (s1_mode_q)
         MODE_MASK: begin
            if (s1_gain_q == '0) begin
               res_real = '0;
               res_imag = '0;
            end
         end
         MODE_GAIN: begin
            res_real = scale(s1_real_q, s1_gain_q);
            res_imag = scale(s1_imag_q, s1_gain_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      shadow_d     = shadow_q;
      active_d     = active_q;
      pending_d    = pending_q;
      bin_d        = bin_q;
      frame_mode_d = frame_mode_q;
      s1_valid_d   = s1_valid_q;
      s1_real_d    = s1_real_q;
      s1_imag_d    = s1_imag_q;
      s1_bin_d     = s1_bin_q;
      s1_gain_d    = s1_gain_q;
      s1_mode_d    = s1_mode_q;
      out_valid_d  = out_valid_q;
      out_real_d   = out_real_q;
      out_imag_d   = out_imag_q;
      out_bin_d    = out_bin_q;
      out_last_d   = out_last_q;
      frame_done_d = out_valid_q && out_ready && out_last_q;

      if (cfg_we) shadow_d[cfg_addr] = cfg_gain;
      if (copy_en) active_d = shadow_q;
      pending_d = copy_en ? 1'b0 : (pending_q || cfg_commit);

      if (accept) begin
         bin_d = bin_q + 1'b1;
         if (bin_q == '0) frame_mode_d = mode;
      end

      if (in_ready) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_real_d = in_real;
            s1_imag_d = in_imag;
            s1_bin_d  = bin_q;
            s1_gain_d = active_q[bin_q];
            s1_mode_d = (bin_q == '0) ? mode : frame_mode_q;
         end
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_real_d = res_real;
            out_imag_d = res_imag;
            out_bin_d  = s1_bin_q;
            out_last_d = (s1_bin_q == LAST_BIN);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= GAIN_ONE;
            active_q[i] <= GAIN_ONE;
         end
         pending_q    <= 1'b0;
         bin_q        <= '0;
         frame_mode_q <= MODE_BYPASS;
         s1_valid_q   <= 1'b0;
         s1_real_q    <= '0;
         s1_imag_q    <= '0;
         s1_bin_q     <= '0;
         s1_gain_q    <= '0;
         s1_mode_q    <= MODE_BYPASS;
         out_valid_q  <= 1'b0;
         out_real_q   <= '0;
         out_imag_q   <= '0;
         out_bin_q    <= '0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         bin_q        <= bin_d;
         frame_mode_q <= frame_mode_d;
         s1_valid_q   <= s1_valid_d;
         s1_real_q    <= s1_real_d;
         s1_imag_q    <= s1_imag_d;
         s1_bin_q     <= s1_bin_d;
         s1_gain_q    <= s1_gain_d;
         s1_mode_q    <= s1_mode_d;
         out_valid_q  <= out_valid_d;
         out_real_q   <= out_real_d;
         out_imag_q   <= out_imag_d;
         out_bin_q    <= out_bin_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_real    = out_real_q;
   assign out_imag    = out_imag_q;
   assign out_bin     = out_bin_q;
   assign out_last    = out_last_q;
   assign frame_done  = frame_done_q;
   assign commit_busy = pending_q;

endmodule

// File: tb/tb_freq_filter_stream.sv
// tb/tb_freq_filter_stream.sv - directed self-checking bench for freq_filter_stream
module tb_freq_filter_stream;

   localparam int DW = 16;
   localparam int GW = 16;
   localparam int N  = 16;
   localparam int AW = 4;

   logic                 clk;
   logic                 reset_n;
   logic [1:0]           mode;
   logic                 in_valid, in_ready;
   logic signed [DW-1:0] in_real, in_imag;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [GW-1:0]        cfg_gain;
   logic                 cfg_commit;
   logic                 out_valid, out_ready;
   logic signed [DW-1:0] out_real, out_imag;
   logic [AW-1:0]        out_bin;
   logic                 out_last, frame_done, commit_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
      logic [AW-1:0]        bin;
      logic                 last;
      int                   cyc;
   } beat_t;

   beat_t obeats[$];
   int    acc_cyc[$];
   int    fd_cyc[$];
   logic signed [DW-1:0] vin_re [N];
   logic signed [DW-1:0] vin_im [N];
   logic signed [DW-1:0] exp_re [N];
   logic signed [DW-1:0] exp_im [N];

   freq_filter_stream #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW), .N(N)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_commit(cfg_commit),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
      .out_bin(out_bin), .out_last(out_last), .frame_done(frame_done), .commit_busy(commit_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready) obeats.push_back('{out_real, out_imag, out_bin, out_last, cyc});
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (frame_done) fd_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      obeats.delete();
      acc_cyc.delete();
      fd_cyc.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic write_gain(input int addr, input logic [GW-1:0] g);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_gain = g;
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   task automatic do_commit();
      cfg_commit = 1'b1;
      @(posedge clk);
      #1 cfg_commit = 1'b0;
      n_checks++;
      if (commit_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_busy_set: got %0b required 1", commit_busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (commit_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_busy_clear_idle: got %0b required 0", commit_busy);
      end
   endtask

   task automatic drive_beat(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
      int w;
      in_valid = 1'b1;
      in_real  = re;
      in_imag  = im;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int nb, input logic [1:0] m0, input logic [1:0] m1, input int commit_at);
      for (int k = 0; k < nb; k++) begin
         mode       = (k == 0) ? m0 : m1;
         cfg_commit = (k == commit_at);
         drive_beat(vin_re[k], vin_im[k]);
      end
      cfg_commit = 1'b0;
      in_valid   = 1'b0;
   endtask

   task automatic test_reset();
      n_checks += 7;
      if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
      if (out_real !== '0)      begin n_fail++; $display("FAIL reset_out_real: got %0d required 0", out_real); end
      if (out_imag !== '0)      begin n_fail++; $display("FAIL reset_out_imag: got %0d required 0", out_imag); end
      if (out_bin !== '0)       begin n_fail++; $display("FAIL reset_out_bin: got %0d required 0", out_bin); end
      if (out_last !== 1'b0)    begin n_fail++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
      if (frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %0b required 0", frame_done); end
      if (commit_busy !== 1'b0) begin n_fail++; $display("FAIL reset_commit_busy: got %0b required 0", commit_busy); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
   endtask

   task automatic test_bypass();
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = DW'(k);
         vin_im[k] = DW'(-k);
      end
      run_frame(N, 2'b00, 2'b00, -1);
      wait_drain();
      n_checks++;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL bypass_count: got %0d required %0d", obeats.size(), N); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks += 3;
         if (obeats[k].re !== vin_re[k] || obeats[k].im !== vin_im[k]) begin
            n_fail++; $display("FAIL bypass_data[%0d]: got (%0d,%0d) required (%0d,%0d)", k, obeats[k].re, obeats[k].im, vin_re[k], vin_im[k]);
         end
         if (obeats[k].bin !== AW'(k) || obeats[k].last !== (k == N - 1)) begin
            n_fail++; $display("FAIL bypass_bin_last[%0d]: got bin %0d last %0b", k, obeats[k].bin, obeats[k].last);
         end
         if (k < acc_cyc.size() && obeats[k].cyc - acc_cyc[k] !== 2) begin
            n_fail++; $display("FAIL bypass_latency[%0d]: got %0d required 2", k, obeats[k].cyc - acc_cyc[k]);
         end
      end
      n_checks++;
      if (fd_cyc.size() !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d required 1", fd_cyc.size()); end
      if (fd_cyc.size() == 1 && obeats.size() == N) begin
         n_checks++;
         if (fd_cyc[0] !== obeats[N-1].cyc + 1) begin
            n_fail++; $display("FAIL frame_done_timing: got cycle %0d required %0d", fd_cyc[0], obeats[N-1].cyc + 1);
         end
      end
   endtask

   task automatic test_mask();
      for (int k = 1; k < N; k += 2) write_gain(k, 16'h0000);
      do_commit();
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = 16'sd100;
         vin_im[k] = 16'sd50;
         exp_re[k] = (k % 2 == 1) ? 16'sd0 : 16'sd100;
         exp_im[k] = (k % 2 == 1) ? 16'sd0 : 16'sd50;
      end
      run_frame(N, 2'b01, 2'b00, -1);
      wait_drain();
      n_checks++;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL mask_count: got %0d required %0d", obeats.size(), N); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks++;
         if (obeats[k].re !== exp_re[k] || obeats[k].im !== exp_im[k]) begin
            n_fail++; $display("FAIL mask_data[%0d]: got (%0d,%0d) required (%0d,%0d)", k, obeats[k].re, obeats[k].im, exp_re[k], exp_im[k]);
         end
      end
   endtask

   task automatic test_gain();
      do_reset();
      write_gain(3, 16'h4000);
      do_commit();
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = (k == 3) ? 16'sd1001 : 16'sd1000;
         vin_im[k] = (k == 3) ? -16'sd1001 : -16'sd1000;
         exp_re[k] = (k == 3) ? 16'sd501 : 16'sd1000;
         exp_im[k] = (k == 3) ? -16'sd500 : -16'sd1000;
      end
      run_frame(N, 2'b10, 2'b10, -1);
      wait_drain();
      n_checks++;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL gain_count: got %0d required %0d", obeats.size(), N); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks++;
         if (obeats[k].re !== exp_re[k] || obeats[k].im !== exp_im[k]) begin
            n_fail++; $display("FAIL gain_data[%0d]: got (%0d,%0d) required (%0d,%0d)", k, obeats[k].re, obeats[k].im, exp_re[k], exp_im[k]);
         end
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < N; k++) write_gain(k, 16'h8000);
      do_commit();
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = (k == 0) ? -16'sd32768 : 16'sd100;
         vin_im[k] = (k == 0) ? 16'sd32767 : -16'sd3;
         exp_re[k] = (k == 0) ? 16'sd32767 : -16'sd100;
         exp_im[k] = (k == 0) ? -16'sd32767 : 16'sd3;
      end
      run_frame(N, 2'b10, 2'b10, -1);
      wait_drain();
      n_checks++;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL sat_count: got %0d required %0d", obeats.size(), N); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks++;
         if (obeats[k].re !== exp_re[k] || obeats[k].im !== exp_im[k]) begin
            n_fail++; $display("FAIL sat_data[%0d]: got (%0d,%0d) required (%0d,%0d)", k, obeats[k].re, obeats[k].im, exp_re[k], exp_im[k]);
         end
      end
   endtask

   task automatic test_stall();
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = DW'(k * 3);
         vin_im[k] = DW'(k + 7);
      end
      fork
         run_frame(N, 2'b00, 2'b00, -1);
         begin
            int w;
            w = 0;
            @(negedge clk);
            while (!(out_valid && out_bin == 4'd5) && w < 100) begin
               @(negedge clk);
               w++;
            end
            if (!(out_valid && out_bin == 4'd5)) begin
               n_checks++; n_fail++; $display("FAIL stall_wait: bin 5 never valid within %0d cycles", w);
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            n_checks += 2;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b required 0", in_ready); end
            if (out_valid !== 1'b1 || out_bin !== 4'd6) begin
               n_fail++; $display("FAIL stall_head: got valid %0b bin %0d required valid 1 bin 6", out_valid, out_bin);
            end
            repeat (5) @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_bin !== 4'd6 || out_real !== 16'sd18) begin
               n_fail++; $display("FAIL stall_hold: got valid %0b bin %0d real %0d required 1 6 18", out_valid, out_bin, out_real);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      n_checks++;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL stall_count: got %0d required %0d", obeats.size(), N); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks++;
         if (obeats[k].bin !== AW'(k) || obeats[k].re !== vin_re[k] || obeats[k].im !== vin_im[k]) begin
            n_fail++; $display("FAIL stall_order[%0d]: got bin %0d (%0d,%0d) required bin %0d (%0d,%0d)", k, obeats[k].bin, obeats[k].re, obeats[k].im, k, vin_re[k], vin_im[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < N; k++) write_gain(k, 16'h0000);
      clear_log();
      for (int k = 0; k < N; k++) begin
         vin_re[k] = 16'sd200;
         vin_im[k] = -16'sd7;
      end
      run_frame(N, 2'b01, 2'b01, 5);
      n_checks++;
      if (commit_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_commit_applied: got %0b required 0", commit_busy); end
      run_frame(N, 2'b01, 2'b01, -1);
      wait_drain();
      n_checks += 2;
      if (obeats.size() !== 2 * N) begin n_fail++; $display("FAIL b2b_count: got %0d required %0d", obeats.size(), 2 * N); end
      if (fd_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d required 2", fd_cyc.size()); end
      for (int k = 0; k < obeats.size() && k < 2 * N; k++) begin
         n_checks++;
         if (obeats[k].re !== ((k < N) ? 16'sd200 : 16'sd0) || obeats[k].im !== ((k < N) ? -16'sd7 : 16'sd0)) begin
            n_fail++; $display("FAIL b2b_data[%0d]: got (%0d,%0d) required %s", k, obeats[k].re, obeats[k].im, (k < N) ? "(200,-7)" : "(0,0)");
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int nlast;
      run_frame(10, 2'b00, 2'b00, 2);
      reset_n = 1'b0;
      #1;
      n_checks += 7;
      if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_out_valid: got %0b required 0", out_valid); end
      if (out_real !== '0)      begin n_fail++; $display("FAIL mid_reset_out_real: got %0d required 0", out_real); end
      if (out_imag !== '0)      begin n_fail++; $display("FAIL mid_reset_out_imag: got %0d required 0", out_imag); end
      if (out_bin !== '0)       begin n_fail++; $display("FAIL mid_reset_out_bin: got %0d required 0", out_bin); end
      if (out_last !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_out_last: got %0b required 0", out_last); end
      if (frame_done !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_frame_done: got %0b required 0", frame_done); end
      if (commit_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_commit_busy: got %0b required 0", commit_busy); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      clear_log();
      wait_drain();
      n_checks++;
      if (obeats.size() !== 0 || fd_cyc.size() !== 0) begin
         n_fail++; $display("FAIL mid_reset_flush: got %0d beats %0d frame_done required 0 0", obeats.size(), fd_cyc.size());
      end
      run_frame(N, 2'b01, 2'b01, -1);
      wait_drain();
      nlast = 0;
      foreach (obeats[k]) if (obeats[k].last) nlast++;
      n_checks += 2;
      if (obeats.size() !== N) begin n_fail++; $display("FAIL post_reset_count: got %0d required %0d", obeats.size(), N); end
      if (nlast !== 1) begin n_fail++; $display("FAIL post_reset_last_count: got %0d required 1", nlast); end
      for (int k = 0; k < obeats.size() && k < N; k++) begin
         n_checks++;
         if (obeats[k].bin !== AW'(k) || obeats[k].re !== 16'sd200 || obeats[k].im !== -16'sd7) begin
            n_fail++; $display("FAIL post_reset_data[%0d]: got bin %0d (%0d,%0d) required bin %0d (200,-7)", k, obeats[k].bin, obeats[k].re, obeats[k].im, k);
         end
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      mode       = 2'b00;
      in_valid   = 1'b0;
      in_real    = '0;
      in_imag    = '0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_gain   = '0;
      cfg_commit = 1'b0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_bypass();
      test_mask();
      test_gain();
      test_saturate();
      test_stall();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
